// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {pc, instr}.
// Ports: clk, reset (sync, active-high); push side in_valid/in_pc/in_instr/in_ready;
// pop side out_valid/out_pc/out_instr/out_op/out_ready; flush clears; count = occupancy.
module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [5:0]               out_op,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready/valid come only from registered occupancy, so a
  // same-cycle pop never opens a slot for a push.
  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count     = count_q;

  assign out_pc    = pc_q[head_q];
  assign out_instr = instr_q[head_q];
  assign out_op    = instr_q[head_q][31:26];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head read is never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[tail_q]    <= in_pc;
      instr_q[tail_q] <= in_instr;
    end
  end

endmodule
